// File: rtl/serdes_tx_sched.sv
// serdes_tx_sched
//   Transmit-side scheduler that shares one serializer byte input between
//   N_REQ byte producers. After enable, it sends TRAIN_LEN SYNC bytes as a
//   link-training preamble. It then offers one slot every DATA_W clocks,
//   arbitrated round-robin. Empty slots either carry a SYNC fill byte
//   (IDLE_FILL=1) or no load at all (IDLE_FILL=0).
//
// Ports
//   clk       in   rising-edge clock
//   nreset    in   asynchronous reset, active-low
//   enable    in   link enable, sampled at slot decision edges only
//   req       in   per-requester byte pending, held until granted
//   req_data  in   requester i byte at [i*DATA_W +: DATA_W]
//   grant     out  one-hot pulse, coincident with ser_load, byte taken
//   ser_load  out  pulse: serializer loads ser_data this clock
//   ser_data  out  byte to serializer, held between loads
//   ser_sync  out  qualifies ser_load: byte is a training/fill SYNC
//   trained   out  preamble complete (RUN state)
//   sent_cnt  out  granted data bytes, wrapping 16-bit count
module serdes_tx_sched #(
    parameter int                N_REQ     = 4,
    parameter int                DATA_W    = 8,
    parameter logic [DATA_W-1:0] SYNC_BYTE = 8'hBC,
    parameter int                TRAIN_LEN = 4,
    parameter bit                IDLE_FILL = 1'b1
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic                      enable,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          grant,
    output logic                      ser_load,
    output logic [DATA_W-1:0]         ser_data,
    output logic                      ser_sync,
    output logic                      trained,
    output logic [15:0]               sent_cnt
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int PTR_W = $clog2(N_REQ);
    localparam int TRN_W = $clog2(TRAIN_LEN + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRAIN = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   slot_cnt, slot_nxt;
    logic [TRN_W-1:0]   train_cnt, train_nxt;
    logic [PTR_W-1:0]   rr_ptr, rr_nxt;
    logic [N_REQ-1:0]   grant_nxt;
    logic               load_nxt;
    logic [DATA_W-1:0]  data_nxt;
    logic               sync_nxt;
    logic               trained_nxt;
    logic [15:0]        sent_nxt;

    logic               slot_end;
    logic               pick_vld;
    logic [PTR_W-1:0]   pick_idx;

    // Index arithmetic modulo N_REQ for values in 0 .. 2*N_REQ-1; avoids a
    // general modulo operator for non-power-of-two requester counts.
    function automatic logic [PTR_W-1:0] wrap_idx(input int v);
        return (v >= N_REQ) ? PTR_W'(v - N_REQ) : PTR_W'(v);
    endfunction

    assign slot_end = (slot_cnt == CNT_W'(DATA_W - 1));

    // Round-robin pick: first set request scanning upward from rr_ptr.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!pick_vld && req[wrap_idx(int'(rr_ptr) + k)]) begin
                pick_vld = 1'b1;
                pick_idx = wrap_idx(int'(rr_ptr) + k);
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt   = state;
        slot_nxt    = slot_cnt;
        train_nxt   = train_cnt;
        rr_nxt      = rr_ptr;
        grant_nxt   = '0;
        load_nxt    = 1'b0;
        data_nxt    = ser_data;
        sync_nxt    = ser_sync;
        trained_nxt = trained;
        sent_nxt    = sent_cnt;

        case (state)
            ST_IDLE: begin
                slot_nxt = '0;
                if (enable) begin
                    // First preamble byte goes out on the very next clock.
                    state_nxt = ST_TRAIN;
                    train_nxt = TRN_W'(1);
                    load_nxt  = 1'b1;
                    data_nxt  = SYNC_BYTE;
                    sync_nxt  = 1'b1;
                end
            end

            default: begin
                slot_nxt = slot_end ? '0 : slot_cnt + 1'b1;
                if (slot_end) begin
                    if (!enable) begin
                        // Enable wins over any pending request at this edge.
                        state_nxt   = ST_IDLE;
                        trained_nxt = 1'b0;
                        slot_nxt    = '0;
                    end else if (state == ST_TRAIN &&
                                 train_cnt != TRN_W'(TRAIN_LEN)) begin
                        train_nxt = train_cnt + 1'b1;
                        load_nxt  = 1'b1;
                        data_nxt  = SYNC_BYTE;
                        sync_nxt  = 1'b1;
                    end else begin
                        // End of the last training slot is already a RUN
                        // decision, so a pending request is served here.
                        state_nxt   = ST_RUN;
                        trained_nxt = 1'b1;
                        if (pick_vld) begin
                            grant_nxt[pick_idx] = 1'b1;
                            load_nxt = 1'b1;
                            data_nxt = req_data[int'(pick_idx)*DATA_W +: DATA_W];
                            sync_nxt = 1'b0;
                            rr_nxt   = wrap_idx(int'(pick_idx) + 1);
                            sent_nxt = sent_cnt + 16'd1;
                        end else if (IDLE_FILL) begin
                            load_nxt = 1'b1;
                            data_nxt = SYNC_BYTE;
                            sync_nxt = 1'b1;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= ST_IDLE;
            slot_cnt  <= '0;
            train_cnt <= '0;
            rr_ptr    <= '0;
            grant     <= '0;
            ser_load  <= 1'b0;
            ser_data  <= '0;
            ser_sync  <= 1'b0;
            trained   <= 1'b0;
            sent_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            slot_cnt  <= slot_nxt;
            train_cnt <= train_nxt;
            rr_ptr    <= rr_nxt;
            grant     <= grant_nxt;
            ser_load  <= load_nxt;
            ser_data  <= data_nxt;
            ser_sync  <= sync_nxt;
            trained   <= trained_nxt;
            sent_cnt  <= sent_nxt;
        end
    end

endmodule

// File: tb/tb_serdes_tx_sched.sv
// tb_serdes_tx_sched
//   Directed bench for serdes_tx_sched. The main instance uses the default
//   parameters (4 requesters, 8-clock slots, 4 training bytes, SYNC fill).
//   A second instance (2 requesters, 1-clock slots, 1 training byte, no
//   fill) covers the empty-slot no-load mode and the 16-bit sent_cnt wrap.
module tb_serdes_tx_sched;

    typedef struct {
        logic        en;
        logic [3:0]  req;
        logic [31:0] rdata;
        int          clks;
        logic        load;
        logic [3:0]  grant;
        logic [7:0]  data;
        logic        sync;
        logic        trained;
        logic [15:0] sent;
    } vec_t;

    localparam logic [31:0] RD  = 32'h335A2211;  // req3..req0 = 33,5A,22,11
    localparam logic [31:0] RD2 = 32'hC35A2296;  // req3..req0 = C3,5A,22,96

    logic        clk;
    logic        nreset;
    logic        en;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  grant;
    logic        ser_load;
    logic [7:0]  ser_data;
    logic        ser_sync;
    logic        trained;
    logic [15:0] sent_cnt;

    logic        en2;
    logic [1:0]  req2;
    logic [1:0]  rd2;
    logic [1:0]  grant2;
    logic        load2;
    logic [0:0]  data2;
    logic        sync2;
    logic        trained2;
    logic [15:0] sent2;

    int n_vec = 0;
    int n_err = 0;

    serdes_tx_sched dut (
        .clk      (clk),
        .nreset   (nreset),
        .enable   (en),
        .req      (req),
        .req_data (req_data),
        .grant    (grant),
        .ser_load (ser_load),
        .ser_data (ser_data),
        .ser_sync (ser_sync),
        .trained  (trained),
        .sent_cnt (sent_cnt)
    );

    serdes_tx_sched #(
        .N_REQ     (2),
        .DATA_W    (1),
        .SYNC_BYTE (1'b1),
        .TRAIN_LEN (1),
        .IDLE_FILL (1'b0)
    ) dut2 (
        .clk      (clk),
        .nreset   (nreset),
        .enable   (en2),
        .req      (req2),
        .req_data (rd2),
        .grant    (grant2),
        .ser_load (load2),
        .ser_data (data2),
        .ser_sync (sync2),
        .trained  (trained2),
        .sent_cnt (sent2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return 64'({grant, ser_load, ser_data, ser_sync, trained, sent_cnt});
    endfunction

    function automatic vec_t mk(input logic e, input logic [3:0] r, input logic [31:0] d,
                                input int c, input logic l, input logic [3:0] g,
                                input logic [7:0] dt, input logic s, input logic t,
                                input logic [15:0] n);
        vec_t v;
        v.en = e; v.req = r; v.rdata = d; v.clks = c;
        v.load = l; v.grant = g; v.data = dt; v.sync = s; v.trained = t; v.sent = n;
        return v;
    endfunction

    // Drive inputs, advance v.clks clocks, require silence on intermediate
    // clocks, then compare the outputs of the slot that just opened.
    task automatic run_vec(input vec_t v, input string tag);
        int bad_mid;
        en = v.en; req = v.req; req_data = v.rdata;
        bad_mid = 0;
        for (int i = 0; i < v.clks; i++) begin
            tick();
            if (i < v.clks - 1 && (ser_load !== 1'b0 || grant !== 4'h0)) bad_mid++;
        end
        if (v.clks > 1) check({tag, ".midslot_quiet"}, 64'(bad_mid), 64'(0));
        check({tag, ".ser_load"}, 64'(ser_load), 64'(v.load));
        check({tag, ".grant"},    64'(grant),    64'(v.grant));
        check({tag, ".ser_data"}, 64'(ser_data), 64'(v.data));
        if (v.load) check({tag, ".ser_sync"}, 64'(ser_sync), 64'(v.sync));
        check({tag, ".trained"},  64'(trained),  64'(v.trained));
        check({tag, ".sent_cnt"}, 64'(sent_cnt), 64'(v.sent));
    endtask

    vec_t tbl [15];

    initial begin
        int bad;
        int gcnt;
        logic [1:0]  eg;
        logic [15:0] s_ffff;
        logic [15:0] s_wrap;

        en = 1'b0; req = 4'h0; req_data = 32'h0;
        en2 = 1'b0; req2 = 2'b00; rd2 = 2'b00;
        nreset = 1'b1;
        #1 nreset = 1'b0;
        #1;
        check("reset.async_outs", outs(), 64'(0));
        tick(); tick();
        check("reset.held_outs", outs(), 64'(0));
        check("reset.dut2_outs", 64'({grant2, load2, data2, sync2, trained2, sent2}), 64'(0));
        nreset = 1'b1;
        tick();
        check("idle.quiet_outs", outs(), 64'(0));

        // Preamble, fill, round-robin, skip, single requester, fill.
        tbl[0]  = mk(1'b1, 4'h0,    RD,  1, 1'b1, 4'h0,    8'hBC, 1'b1, 1'b0, 16'd0);
        tbl[1]  = mk(1'b1, 4'h0,    RD,  8, 1'b1, 4'h0,    8'hBC, 1'b1, 1'b0, 16'd0);
        tbl[2]  = mk(1'b1, 4'h0,    RD,  8, 1'b1, 4'h0,    8'hBC, 1'b1, 1'b0, 16'd0);
        tbl[3]  = mk(1'b1, 4'h0,    RD,  8, 1'b1, 4'h0,    8'hBC, 1'b1, 1'b0, 16'd0);
        tbl[4]  = mk(1'b1, 4'h0,    RD,  8, 1'b1, 4'h0,    8'hBC, 1'b1, 1'b1, 16'd0);
        tbl[5]  = mk(1'b1, 4'hF,    RD,  8, 1'b1, 4'b0001, 8'h11, 1'b0, 1'b1, 16'd1);
        tbl[6]  = mk(1'b1, 4'hF,    RD,  8, 1'b1, 4'b0010, 8'h22, 1'b0, 1'b1, 16'd2);
        tbl[7]  = mk(1'b1, 4'hF,    RD,  8, 1'b1, 4'b0100, 8'h5A, 1'b0, 1'b1, 16'd3);
        tbl[8]  = mk(1'b1, 4'hF,    RD,  8, 1'b1, 4'b1000, 8'h33, 1'b0, 1'b1, 16'd4);
        tbl[9]  = mk(1'b1, 4'hF,    RD,  8, 1'b1, 4'b0001, 8'h11, 1'b0, 1'b1, 16'd5);
        tbl[10] = mk(1'b1, 4'b1001, RD2, 8, 1'b1, 4'b1000, 8'hC3, 1'b0, 1'b1, 16'd6);
        tbl[11] = mk(1'b1, 4'b1001, RD2, 8, 1'b1, 4'b0001, 8'h96, 1'b0, 1'b1, 16'd7);
        tbl[12] = mk(1'b1, 4'b0100, RD,  8, 1'b1, 4'b0100, 8'h5A, 1'b0, 1'b1, 16'd8);
        tbl[13] = mk(1'b1, 4'h0,    RD,  8, 1'b1, 4'h0,    8'hBC, 1'b1, 1'b1, 16'd8);
        tbl[14] = mk(1'b1, 4'b0001, RD,  8, 1'b1, 4'b0001, 8'h11, 1'b0, 1'b1, 16'd9);
        for (int i = 0; i < 15; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Enable dropped 3 clocks into a data slot.
        tick();
        check("drop.slot1_load", 64'(ser_load), 64'(0));
        tick();
        en = 1'b0; req = 4'b1001; req_data = RD2;
        bad = 0;
        repeat (5) begin
            tick();
            if (ser_load !== 1'b0 || trained !== 1'b1) bad++;
        end
        check("drop.trained_held_midslot", 64'(bad), 64'(0));
        tick();
        check("drop.trained_fall", 64'(trained), 64'(0));
        check("drop.no_load", 64'(ser_load), 64'(0));
        check("drop.no_grant", 64'(grant), 64'(0));
        check("drop.data_held", 64'(ser_data), 64'(8'h11));
        bad = 0;
        repeat (6) begin
            tick();
            if (ser_load !== 1'b0 || trained !== 1'b0) bad++;
        end
        check("drop.idle_quiet", 64'(bad), 64'(0));

        // Re-enable: full preamble again, rr_ptr (=1) and sent_cnt kept.
        run_vec(mk(1'b1, 4'b1001, RD2, 1, 1'b1, 4'h0, 8'hBC, 1'b1, 1'b0, 16'd9), "reen0");
        for (int i = 1; i < 4; i++)
            run_vec(mk(1'b1, 4'b1001, RD2, 8, 1'b1, 4'h0, 8'hBC, 1'b1, 1'b0, 16'd9),
                    $sformatf("reen%0d", i));
        run_vec(mk(1'b1, 4'b1001, RD2, 8, 1'b1, 4'b1000, 8'hC3, 1'b0, 1'b1, 16'd10), "reen_grant");

        // Asynchronous reset pulsed between clock edges mid-RUN.
        tick(); tick();
        #2 nreset = 1'b0;
        #1;
        check("rst.async_outs", outs(), 64'(0));
        en = 1'b0;
        #1 nreset = 1'b1;
        bad = 0;
        repeat (3) begin
            tick();
            if (outs() !== 64'(0)) bad++;
        end
        check("rst.idle_outs", 64'(bad), 64'(0));
        run_vec(mk(1'b1, 4'hF, RD, 1, 1'b1, 4'h0, 8'hBC, 1'b1, 1'b0, 16'd0), "rst_pre0");
        for (int i = 1; i < 4; i++)
            run_vec(mk(1'b1, 4'hF, RD, 8, 1'b1, 4'h0, 8'hBC, 1'b1, 1'b0, 16'd0),
                    $sformatf("rst_pre%0d", i));
        run_vec(mk(1'b1, 4'hF, RD, 8, 1'b1, 4'b0001, 8'h11, 1'b0, 1'b1, 16'd1), "rst_grant0");
        en = 1'b0; req = 4'h0;

        // Second instance: no fill in empty slots.
        en2 = 1'b1;
        tick();
        check("nofill.train_load", 64'({load2, sync2, data2, trained2}), 64'(4'b1110));
        tick();
        check("nofill.trained", 64'(trained2), 64'(1));
        check("nofill.first_empty", 64'(load2), 64'(0));
        bad = 0;
        repeat (5) begin
            tick();
            if (load2 !== 1'b0 || grant2 !== 2'b00) bad++;
        end
        check("nofill.5_slots_no_load", 64'(bad), 64'(0));
        check("nofill.data_held", 64'(data2), 64'(1));

        // Second instance: 65536 back-to-back grants wrap sent_cnt.
        req2 = 2'b11; rd2 = 2'b10;
        gcnt = 0; bad = 0;
        s_ffff = 16'h1234; s_wrap = 16'h1234;
        for (int c = 0; c < 70000 && gcnt < 65536; c++) begin
            tick();
            if (load2 === 1'b1) begin
                gcnt++;
                eg = gcnt[0] ? 2'b01 : 2'b10;
                if (grant2 !== eg || data2 !== eg[1] || sync2 !== 1'b0) bad++;
                if (gcnt == 65535) s_ffff = sent2;
                if (gcnt == 65536) s_wrap = sent2;
            end else begin
                bad++;
            end
        end
        check("wrap.grant_count", 64'(gcnt), 64'(65536));
        check("wrap.alternating_grants", 64'(bad), 64'(0));
        check("wrap.sent_ffff", 64'(s_ffff), 64'(16'hFFFF));
        check("wrap.sent_zero", 64'(s_wrap), 64'(16'h0000));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
